posicionamento_frota: RTL and testbench

Parametrised fleet-placement controller for the battleship game. It steps each player through placing every ship of a configurable fleet on an N x N board. Each ship gets direction, orientation, X and Y, then a bounds check, an external conflict check, and a store. It sits between the button debouncers and the board memory/conflict checker. Manual mode is driven by select/enter; automatic mode uses an internal LFSR.

---
 rtl/posicionamento_pkg.sv | 73 +++++++
 rtl/gerador_lfsr.sv | 26 ++
 rtl/posicionamento_frota.sv | 191 +++++++++++++++++++
 tb/tb_posicionamento_frota.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posicionamento_pkg.sv
// Shared types and helpers for the fleet-placement controller: FSM states,
// ship type codes, ship lengths and per-type fleet counts.
package posicionamento_pkg;

  typedef enum logic [3:0] {
    DIRECAO,
    ORIENTACAO,
    DEF_X,
    DEF_Y,
    VERIFICA,
    AGUARDA,
    ARMAZENA,
    PROXIMO,
    PRONTO
  } estado_t;

  localparam logic [2:0] TIPO_SUB   = 3'd1;
  localparam logic [2:0] TIPO_CRUZ  = 3'd2;
  localparam logic [2:0] TIPO_HIDRO = 3'd3;
  localparam logic [2:0] TIPO_ENC   = 3'd4;
  localparam logic [2:0] TIPO_PA    = 3'd5;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right shift)
  localparam logic [15:0] TAPS_LFSR = 16'hB400;

  function automatic logic [2:0] comprimento(input logic [2:0] tipo);
    case (tipo)
      TIPO_SUB:   return 3'd1;
      TIPO_CRUZ:  return 3'd2;
      TIPO_HIDRO: return 3'd3;
      TIPO_ENC:   return 3'd4;
      TIPO_PA:    return 3'd5;
      default:    return 3'd1;
    endcase
  endfunction

  function automatic int unsigned quantidade(
    input logic [2:0]  tipo,
    input int unsigned n_sub,
    input int unsigned n_cruz,
    input int unsigned n_hidro,
    input int unsigned n_enc,
    input int unsigned n_pa
  );
    case (tipo)
      TIPO_SUB:   return n_sub;
      TIPO_CRUZ:  return n_cruz;
      TIPO_HIDRO: return n_hidro;
      TIPO_ENC:   return n_enc;
      TIPO_PA:    return n_pa;
      default:    return 0;
    endcase
  endfunction

  // First type above 'tipo' with a non-zero count; 0 when the fleet is done.
  function automatic logic [2:0] proximo_tipo(
    input logic [2:0]  tipo,
    input int unsigned n_sub,
    input int unsigned n_cruz,
    input int unsigned n_hidro,
    input int unsigned n_enc,
    input int unsigned n_pa
  );
    logic [2:0] res;
    res = '0;
    for (int unsigned t = 5; t >= 1; t--) begin
      if (3'(t) > tipo && quantidade(3'(t), n_sub, n_cruz, n_hidro, n_enc, n_pa) != 0)
        res = 3'(t);
    end
    return res;
  endfunction

endpackage

// File: rtl/gerador_lfsr.sv
// 16-bit Galois LFSR used as the random source for automatic placement;
// the synchronous reset reloads the seed.
module gerador_lfsr
  import posicionamento_pkg::*;
#(
  parameter int unsigned OUT_W = 4,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [OUT_W-1:0] valor
);

  logic [15:0] estado;

  always_ff @(posedge clk) begin
    if (!reset)
      estado <= SEED;
    else if (enable)
      estado <= {1'b0, estado[15:1]} ^ (estado[0] ? TAPS_LFSR : '0);
  end

  always_comb valor = estado[OUT_W-1:0];

endmodule

// File: rtl/posicionamento_frota.sv
// Fleet-placement controller: steps each player through direction, orientation
// and anchor of every ship, runs bounds and external conflict checks, then stores.
module posicionamento_frota
  import posicionamento_pkg::*;
#(
  parameter int unsigned BOARD_SIZE  = 8,
  parameter int unsigned COORD_W     = $clog2(BOARD_SIZE),
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned PLAYER_W    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  parameter int unsigned N_SUB       = 5,
  parameter int unsigned N_CRUZ      = 2,
  parameter int unsigned N_HIDRO     = 2,
  parameter int unsigned N_ENC       = 1,
  parameter int unsigned N_PA        = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                enter,
  input  logic                select,
  input  logic                mode,
  input  logic                conflito,
  input  logic                chk_done,
  output logic                ready,
  output logic                valida,
  output logic                grava,
  output logic                erro,
  output logic [2:0]          tipo,
  output logic [PLAYER_W-1:0] jogador,
  output logic [COORD_W-1:0]  X1,
  output logic [COORD_W-1:0]  Y1,
  output logic                direcao,
  output logic                orientacao
);

  localparam int unsigned         RAND_W    = (COORD_W > 2) ? COORD_W : 2;
  localparam int unsigned         EXT_W     = COORD_W + 4;
  localparam logic [COORD_W-1:0]  COORD_MAX = COORD_W'(BOARD_SIZE - 1);
  localparam logic [PLAYER_W-1:0] ULTIMO    = PLAYER_W'(NUM_PLAYERS - 1);
  localparam logic [2:0]          PRIMEIRO  =
    proximo_tipo(3'd0, N_SUB, N_CRUZ, N_HIDRO, N_ENC, N_PA);

  estado_t            estado;
  logic               modo;
  logic               enter_r, select_r;
  logic               ev_enter, ev_select;
  logic [RAND_W-1:0]  aleatorio;
  logic [COORD_W-1:0] coord_auto, coord_eixo;
  logic               coord_auto_ok, cabe;
  logic [2:0]         comp, tipo_seg;
  logic [7:0]         contagem [8];
  logic [7:0]         conta_prox;
  logic               tipo_completo;

  gerador_lfsr #(
    .OUT_W (RAND_W),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .valor  (aleatorio)
  );

  always_comb begin
    ev_enter      = enter_r & ~enter;
    ev_select     = select_r & ~select & ~ev_enter;
    coord_auto    = aleatorio[COORD_W-1:0];
    coord_auto_ok = EXT_W'(coord_auto) < EXT_W'(BOARD_SIZE);
    comp          = comprimento(tipo);
    coord_eixo    = direcao ? Y1 : X1;
    if (orientacao)
      cabe = EXT_W'(coord_eixo) >= EXT_W'(comp) - EXT_W'(1);
    else
      cabe = EXT_W'(coord_eixo) + EXT_W'(comp) - EXT_W'(1) <= EXT_W'(BOARD_SIZE - 1);
    conta_prox    = contagem[tipo] + 8'd1;
    tipo_completo = 32'(conta_prox) >= quantidade(tipo, N_SUB, N_CRUZ, N_HIDRO, N_ENC, N_PA);
    tipo_seg      = proximo_tipo(tipo, N_SUB, N_CRUZ, N_HIDRO, N_ENC, N_PA);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado     <= DIRECAO;
      modo       <= 1'b0;
      enter_r    <= 1'b1;
      select_r   <= 1'b1;
      ready      <= 1'b0;
      valida     <= 1'b0;
      grava      <= 1'b0;
      erro       <= 1'b0;
      tipo       <= PRIMEIRO;
      jogador    <= '0;
      X1         <= '0;
      Y1         <= '0;
      direcao    <= 1'b0;
      orientacao <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) contagem[i] <= '0;
    end else if (enable) begin
      enter_r  <= enter;
      select_r <= select;
      valida   <= 1'b0;
      grava    <= 1'b0;
      erro     <= 1'b0;
      case (estado)
        DIRECAO: begin
          modo <= mode;
          if (mode) begin
            direcao <= aleatorio[0];
            estado  <= ORIENTACAO;
          end else if (ev_enter) estado <= ORIENTACAO;
          else if (ev_select) direcao <= ~direcao;
        end
        ORIENTACAO: begin
          if (modo) begin
            orientacao <= aleatorio[1];
            estado     <= DEF_X;
          end else if (ev_enter) estado <= DEF_X;
          else if (ev_select) orientacao <= ~orientacao;
        end
        DEF_X: begin
          if (modo) begin
            if (coord_auto_ok) begin
              X1     <= coord_auto;
              estado <= DEF_Y;
            end
          end else if (ev_enter) estado <= DEF_Y;
          else if (ev_select) X1 <= (X1 == COORD_MAX) ? '0 : X1 + COORD_W'(1);
        end
        DEF_Y: begin
          if (modo) begin
            if (coord_auto_ok) begin
              Y1     <= coord_auto;
              estado <= VERIFICA;
            end
          end else if (ev_enter) estado <= VERIFICA;
          else if (ev_select) Y1 <= (Y1 == COORD_MAX) ? '0 : Y1 + COORD_W'(1);
        end
        VERIFICA: begin
          if (cabe) begin
            valida <= 1'b1;
            estado <= AGUARDA;
          end else begin
            erro   <= 1'b1;
            estado <= DEF_X;
          end
        end
        AGUARDA: begin
          // valida is still high on the first AGUARDA cycle: a strobe there is stale
          if (chk_done && !valida) begin
            if (conflito) begin
              erro   <= 1'b1;
              estado <= DEF_X;
            end else estado <= ARMAZENA;
          end
        end
        ARMAZENA: begin
          if (modo || ev_enter) begin
            grava  <= 1'b1;
            estado <= PROXIMO;
          end
        end
        PROXIMO: begin
          X1 <= '0;
          Y1 <= '0;
          if (!tipo_completo) begin
            contagem[tipo] <= conta_prox;
            estado         <= DIRECAO;
          end else if (tipo_seg != '0) begin
            contagem[tipo] <= conta_prox;
            tipo           <= tipo_seg;
            estado         <= DIRECAO;
          end else begin
            for (int unsigned i = 0; i < 8; i++) contagem[i] <= '0;
            tipo <= PRIMEIRO;
            if (jogador == ULTIMO) begin
              ready  <= 1'b1;
              estado <= PRONTO;
            end else begin
              jogador <= jogador + PLAYER_W'(1);
              estado  <= DIRECAO;
            end
          end
        end
        PRONTO:  estado <= PRONTO;
        default: estado <= DIRECAO;
      endcase
    end
  end

endmodule

// File: tb/tb_posicionamento_frota.sv
// Scoreboard bench for posicionamento_frota: stimulus pushes expected strobes,
// a monitor pops and compares them whenever valida/grava/erro fires.
module tb_posicionamento_frota;

  localparam int BS = 8;
  localparam int CW = 3;
  localparam int PW = 1;
  localparam int EV_VALIDA = 0;
  localparam int EV_GRAVA  = 1;
  localparam int EV_ERRO   = 2;

  logic clk = 1'b0;
  logic reset, enable, enter, select, mode, conflito, chk_done;
  logic ready, valida, grava, erro, direcao, orientacao;
  logic [2:0] tipo;
  logic [PW-1:0] jogador;
  logic [CW-1:0] X1, Y1;

  posicionamento_frota #(
    .BOARD_SIZE  (BS),
    .NUM_PLAYERS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .enter      (enter),
    .select     (select),
    .mode       (mode),
    .conflito   (conflito),
    .chk_done   (chk_done),
    .ready      (ready),
    .valida     (valida),
    .grava      (grava),
    .erro       (erro),
    .tipo       (tipo),
    .jogador    (jogador),
    .X1         (X1),
    .Y1         (Y1),
    .direcao    (direcao),
    .orientacao (orientacao)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind; int tipo; int jog; int x; int y; int d; int o; bit full;
  } exp_t;

  exp_t fila[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_grava = 0;
  bit   auto_phase = 1'b0;
  bit   resp_early = 1'b0;
  int   resp_delay = 1;
  logic resp_conf = 1'b0;
  int   cur_dir, cur_ori;
  int   tipo_tab [11] = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 4, 5};

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int in_bounds(input int t, input int x, input int y,
                                   input int d, input int o);
    int c;
    c = (d != 0) ? y : x;
    if (o == 0) return (c + t - 1 <= BS - 1) ? 1 : 0;
    return (c >= t - 1) ? 1 : 0;
  endfunction

  task automatic push_ev(input int k, input int t, input int j, input int x,
                         input int y, input int d, input int o, input bit full);
    exp_t e;
    e.kind = k; e.tipo = t; e.jog = j; e.x = x; e.y = y; e.d = d; e.o = o; e.full = full;
    fila.push_back(e);
  endtask

  // Monitor: pops the next expected strobe whenever the DUT raises one.
  initial begin : monitor
    exp_t e;
    int   k;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (valida || grava || erro)) begin
        k = valida ? EV_VALIDA : (grava ? EV_GRAVA : EV_ERRO);
        if (!(auto_phase && k != EV_GRAVA)) begin
          if (fila.size() == 0) begin
            check("unexpected_strobe", k, -1);
          end else begin
            e = fila.pop_front();
            check("strobe_kind", k, e.kind);
            check("strobe_tipo", int'(tipo), e.tipo);
            check("strobe_jogador", int'(jogador), e.jog);
            if (e.full) begin
              check("strobe_x", int'(X1), e.x);
              check("strobe_y", int'(Y1), e.y);
              check("strobe_dir", int'(direcao), e.d);
              check("strobe_ori", int'(orientacao), e.o);
            end else begin
              check("ship_in_bounds",
                    in_bounds(int'(tipo), int'(X1), int'(Y1), int'(direcao), int'(orientacao)), 1);
            end
            if (k == EV_GRAVA) begin
              n_grava++;
              check("ready_low_while_placing", int'(ready), 0);
              if (n_grava == (auto_phase ? 44 : 22)) begin
                @(negedge clk);
                check("ready_after_last", int'(ready), 1);
              end
            end
          end
        end
      end
    end
  end

  // Checker model: answers each valida after resp_delay cycles.
  initial begin : responder
    chk_done = 1'b0;
    conflito = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && valida) begin
        if (resp_early) begin
          chk_done = 1'b1;
          conflito = ~resp_conf;
        end
        repeat (resp_delay) begin
          @(posedge clk); #1;
          chk_done = 1'b0;
        end
        chk_done = 1'b1;
        conflito = resp_conf;
        @(posedge clk); #1;
        chk_done = 1'b0;
        conflito = 1'b0;
      end
    end
  end

  task automatic press_enter();
    @(posedge clk); #1; enter = 1'b0;
    @(posedge clk); #1; enter = 1'b1;
  endtask

  task automatic press_select(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; select = 1'b0;
      @(posedge clk); #1; select = 1'b1;
    end
  endtask

  task automatic goto_verify(input int x, input int y, input int d, input int o);
    if (d != cur_dir) press_select(1);
    press_enter();
    cur_dir = d;
    if (o != cur_ori) press_select(1);
    press_enter();
    cur_ori = o;
    press_select(x);
    press_enter();
    press_select(y);
    press_enter();
  endtask

  task automatic store_ship(input int t, input int j, input int x, input int y,
                            input int d, input int o);
    repeat (4) @(posedge clk);
    push_ev(EV_GRAVA, t, j, x, y, d, o, 1'b1);
    press_enter();
    repeat (2) @(posedge clk);
  endtask

  task automatic ship_ok(input int t, input int j, input int x, input int y,
                         input int d, input int o);
    push_ev(EV_VALIDA, t, j, x, y, d, o, 1'b1);
    goto_verify(x, y, d, o);
    store_ship(t, j, x, y, d, o);
  endtask

  task automatic do_reset(input logic m);
    reset = 1'b0; mode = m;
    enter = 1'b1; select = 1'b1; enable = 1'b1;
    cur_dir = 0; cur_ori = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin : stimulus
    bit got_ready;
    do_reset(1'b0);
    @(posedge clk); #1;
    check("reset_ready", int'(ready), 0);
    check("reset_tipo", int'(tipo), 1);
    check("reset_jogador", int'(jogador), 0);
    check("reset_x", int'(X1), 0);
    check("reset_y", int'(Y1), 0);
    check("reset_strobes", int'({valida, grava, erro}), 0);

    // Player 0, ship 1: X1=3, Y1=5
    ship_ok(1, 0, 3, 5, 0, 0);

    // Ship 2: wrap, freeze, then a rejected conflict before storing
    press_enter();
    press_enter();
    press_select(9);
    check("wrap_x", int'(X1), 1);
    enable = 1'b0;
    press_select(2);
    enable = 1'b1;
    @(posedge clk); #1;
    check("frozen_x", int'(X1), 1);
    resp_early = 1'b1; resp_delay = 3; resp_conf = 1'b1;
    push_ev(EV_VALIDA, 1, 0, 1, 0, 0, 0, 1'b1);
    push_ev(EV_ERRO, 1, 0, 1, 0, 0, 0, 1'b1);
    press_enter();
    press_enter();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("aguarda_x_stable", int'(X1), 1);
      check("aguarda_y_stable", int'(Y1), 0);
      check("aguarda_tipo_stable", int'(tipo), 1);
      check("aguarda_no_erro_grava", int'({erro, grava}), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    resp_early = 1'b0; resp_delay = 1; resp_conf = 1'b0;
    check("conflict_x_retained", int'(X1), 1);
    push_ev(EV_VALIDA, 1, 0, 1, 0, 0, 0, 1'b1);
    press_enter();
    press_enter();
    store_ship(1, 0, 1, 0, 0, 0);

    for (int s = 2; s < 10; s++) ship_ok(tipo_tab[s], 0, 0, 0, 0, 0);

    // Porta-avioes at X1=4 extending +X does not fit
    push_ev(EV_ERRO, 5, 0, 4, 0, 0, 0, 1'b1);
    goto_verify(4, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("bounds_x_retained", int'(X1), 4);
    push_ev(EV_VALIDA, 5, 0, 0, 0, 0, 0, 1'b1);
    press_select(4);
    check("bounds_x_rewrap", int'(X1), 0);
    press_enter();
    press_enter();
    store_ship(5, 0, 0, 0, 0, 0);

    check("player1_jogador", int'(jogador), 1);
    check("player1_tipo", int'(tipo), 1);
    for (int s = 0; s < 10; s++) ship_ok(tipo_tab[s], 1, 2, s % 8, 0, 0);
    // Porta-avioes at X1=4 extending -X fits exactly
    ship_ok(5, 1, 4, 7, 0, 1);
    press_enter();
    press_select(2);
    @(posedge clk); #1;
    check("manual_ready_held", int'(ready), 1);
    check("manual_queue_drained", fila.size(), 0);
    fila.delete();

    // Automatic run over both players
    auto_phase = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 11; s++) push_ev(EV_GRAVA, tipo_tab[s], p, 0, 0, 0, 0, 1'b0);
    do_reset(1'b1);
    got_ready = 1'b0;
    for (int i = 0; i < 20000 && !got_ready; i++) begin
      @(posedge clk); #1;
      if (ready) got_ready = 1'b1;
    end
    check("auto_ready_reached", int'(got_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    check("auto_queue_drained", fila.size(), 0);
    check("auto_ready_held", int'(ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
